// File: rtl/frame_scanner.sv
// frame_scanner: walks the frame buffer in raster order and emits addr/x/y/data per pixel.
// Pixel appears RD_LAT+1 cycles after its mem_en; hold stalls issue only, in-flight reads always drain.
module frame_scanner #(
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int ADDR_W       = 19,
    parameter int DATA_W       = 12,
    parameter int RD_LAT       = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              hold_i,
    output logic              mem_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              pix_valid_o,
    output logic [ADDR_W-1:0] pix_addr_o,
    output logic [9:0]        pix_x_o,
    output logic [8:0]        pix_y_o,
    output logic [DATA_W-1:0] pix_data_o,
    output logic              pix_sof_o,
    output logic              pix_eof_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMAGE_WIDTH * IMAGE_HEIGHT - 1);
    localparam logic [9:0]        LAST_X    = 10'(IMAGE_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] addr;
        logic [9:0]        x;
        logic [8:0]        y;
        logic              sof;
        logic              eof;
    } tag_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [9:0]        x_q, x_d;
    logic [8:0]        y_q, y_d;
    tag_t              iss_q, iss_d;
    tag_t              pipe_q [RD_LAT];
    tag_t              out_q;
    logic [DATA_W-1:0] data_q;

    logic [ADDR_W-1:0] cur_addr;
    logic [9:0]        cur_x;
    logic [8:0]        cur_y;
    logic              do_issue;
    logic              in_flight;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        x_d       = x_q;
        y_d       = y_q;
        iss_d     = iss_q;
        iss_d.vld = 1'b0;
        cur_addr  = addr_q;
        cur_x     = x_q;
        cur_y     = y_q;
        do_issue  = 1'b0;

        in_flight = iss_q.vld;
        for (int i = 0; i < RD_LAT; i++) begin
            in_flight = in_flight | pipe_q[i].vld;
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = SCAN;
                    addr_d   = '0;
                    x_d      = '0;
                    y_d      = '0;
                    cur_addr = '0;
                    cur_x    = '0;
                    cur_y    = '0;
                    do_issue = !hold_i;
                end
            end
            SCAN:    do_issue = !hold_i;
            DRAIN:   if (!in_flight) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // The start edge itself issues pixel 0, so mem_en follows start by one cycle.
        if (do_issue) begin
            iss_d.vld  = 1'b1;
            iss_d.addr = cur_addr;
            iss_d.x    = cur_x;
            iss_d.y    = cur_y;
            iss_d.sof  = (cur_addr == '0);
            iss_d.eof  = (cur_addr == LAST_ADDR);
            if (cur_addr == LAST_ADDR) begin
                state_d = DRAIN;
            end else begin
                addr_d = cur_addr + 1'b1;
                if (cur_x == LAST_X) begin
                    x_d = '0;
                    y_d = cur_y + 9'd1;
                end else begin
                    x_d = cur_x + 10'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            iss_q   <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= '0;
            end
            out_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            x_q       <= x_d;
            y_q       <= y_d;
            iss_q     <= iss_d;
            pipe_q[0] <= iss_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            // Output fields only load on a valid beat so they hold their last pixel in gaps.
            out_q.vld <= pipe_q[RD_LAT-1].vld;
            if (pipe_q[RD_LAT-1].vld) begin
                out_q  <= pipe_q[RD_LAT-1];
                data_q <= mem_rdata_i;
            end
        end
    end

    assign mem_en_o    = iss_q.vld;
    assign mem_addr_o  = iss_q.addr;
    assign pix_valid_o = out_q.vld;
    assign pix_addr_o  = out_q.addr;
    assign pix_x_o     = out_q.x;
    assign pix_y_o     = out_q.y;
    assign pix_data_o  = data_q;
    assign pix_sof_o   = out_q.vld & out_q.sof;
    assign pix_eof_o   = out_q.vld & out_q.eof;
    assign busy_o      = (state_q == SCAN) || (state_q == DRAIN);
    assign done_o      = (state_q == DONE);

endmodule

// File: tb/tb_frame_scanner.sv
// Bench for frame_scanner: three configurations (8x4 lat1, 8x4 lat3, 640-wide lat1) against a raster-order model.
module tb_frame_scanner;

    localparam int NI = 3;
    localparam int CFG_W [NI] = '{8, 8, 640};
    localparam int CFG_H [NI] = '{4, 4, 8};
    localparam int CFG_L [NI] = '{1, 3, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] rst_v, start_v, hold_v;
    logic [NI-1:0] en_v, vld_v, sof_v, eof_v, busy_v, done_v;
    logic [18:0]   maddr_a [NI];
    logic [18:0]   paddr_a [NI];
    logic [9:0]    px_a    [NI];
    logic [8:0]    py_a    [NI];
    logic [11:0]   pdat_a  [NI];
    logic [11:0]   rdat_a  [NI];

    // Instances 0/1 store data=address; instance 2 stores 0xFFF only at address 1283.
    function automatic logic [11:0] mem_word(input int inst, input int a);
        if (inst == 2) return (a == 1283) ? 12'hFFF : 12'h000;
        return a[11:0];
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        logic [11:0] rd_line [4];

        frame_scanner #(
            .IMAGE_WIDTH (CFG_W[g]),
            .IMAGE_HEIGHT(CFG_H[g]),
            .ADDR_W      (19),
            .DATA_W      (12),
            .RD_LAT      (CFG_L[g])
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_v[g]),
            .start_i    (start_v[g]),
            .hold_i     (hold_v[g]),
            .mem_en_o   (en_v[g]),
            .mem_addr_o (maddr_a[g]),
            .mem_rdata_i(rdat_a[g]),
            .pix_valid_o(vld_v[g]),
            .pix_addr_o (paddr_a[g]),
            .pix_x_o    (px_a[g]),
            .pix_y_o    (py_a[g]),
            .pix_data_o (pdat_a[g]),
            .pix_sof_o  (sof_v[g]),
            .pix_eof_o  (eof_v[g]),
            .busy_o     (busy_v[g]),
            .done_o     (done_v[g])
        );

        always @(posedge clk) begin
            rd_line[0] <= en_v[g] ? mem_word(g, int'(maddr_a[g])) : 12'hA5A;
            for (int s = 1; s < 4; s++) rd_line[s] <= rd_line[s-1];
        end
        assign rdat_a[g] = rd_line[CFG_L[g]-1];
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int req_id = 0;
    int req_seq = 0;
    int seen_seq = 0;
    int tmo_cnt = 0;

    int m_state [NI];
    int m_k [NI];
    int m_b [NI];
    logic exp_en [NI];
    logic [7:0] hist [NI];
    int st_c [NI], fen_c [NI], fv_c [NI], eof_c [NI], done_c [NI];
    int beats [NI], sofs [NI], eofs [NI], dones [NI];
    int bc5 [NI], bc6 [NI], bc30 [NI], bc31 [NI];
    int b7x [NI], b7y [NI], b8x [NI], b8y [NI];
    int ffn [NI], ffx [NI], ffy [NI], lx [NI], ly [NI], la [NI];

    task automatic chk(input int i, input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s inst%0d cycle %0d: got %0d expected %0d", nm, i, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < NI; i++) begin : per_inst
            int w;
            int n;
            logic ev;
            logic eof_now;
            w = CFG_W[i];
            n = CFG_W[i] * CFG_H[i];
            eof_now = 1'b0;
            if (!rst_v[i]) begin
                chk(i, "reset_outputs", int'(|{en_v[i], maddr_a[i], vld_v[i], paddr_a[i], px_a[i], py_a[i],
                    pdat_a[i], sof_v[i], eof_v[i], busy_v[i], done_v[i]}), 0);
                m_state[i] = 0;
                m_k[i] = 0;
                m_b[i] = 0;
                exp_en[i] = 1'b0;
                hist[i] = '0;
            end else begin
                chk(i, "mem_en", int'(en_v[i]), int'(exp_en[i]));
                if (en_v[i]) begin
                    chk(i, "mem_addr", int'(maddr_a[i]), m_k[i]);
                    if (fen_c[i] < 0) fen_c[i] = cyc;
                    m_k[i]++;
                end
                // A beat is due exactly RD_LAT+1 cycles after its mem_en cycle.
                ev = hist[i][CFG_L[i]];
                chk(i, "pix_valid", int'(vld_v[i]), int'(ev));
                if (ev) begin
                    if (vld_v[i]) begin
                        chk(i, "pix_addr", int'(paddr_a[i]), m_b[i]);
                        chk(i, "pix_x", int'(px_a[i]), m_b[i] % w);
                        chk(i, "pix_y", int'(py_a[i]), m_b[i] / w);
                        chk(i, "pix_data", int'(pdat_a[i]), int'(mem_word(i, m_b[i])));
                        chk(i, "pix_sof", int'(sof_v[i]), int'(m_b[i] == 0));
                        chk(i, "pix_eof", int'(eof_v[i]), int'(m_b[i] == n - 1));
                    end
                    if (m_b[i] == 5) bc5[i] = cyc;
                    if (m_b[i] == 6) bc6[i] = cyc;
                    if (m_b[i] == 30) bc30[i] = cyc;
                    if (m_b[i] == 31) bc31[i] = cyc;
                    if (m_b[i] == 7) begin b7x[i] = int'(px_a[i]); b7y[i] = int'(py_a[i]); end
                    if (m_b[i] == 8) begin b8x[i] = int'(px_a[i]); b8y[i] = int'(py_a[i]); end
                    if (m_b[i] == n - 1) eof_now = 1'b1;
                    m_b[i]++;
                end
                if (vld_v[i]) begin
                    beats[i]++;
                    if (fv_c[i] < 0) fv_c[i] = cyc;
                    if (pdat_a[i] == 12'hFFF) begin ffn[i]++; ffx[i] = int'(px_a[i]); ffy[i] = int'(py_a[i]); end
                end
                if (sof_v[i]) sofs[i]++;
                if (eof_v[i]) begin
                    eofs[i]++;
                    eof_c[i] = cyc;
                    lx[i] = int'(px_a[i]);
                    ly[i] = int'(py_a[i]);
                    la[i] = int'(paddr_a[i]);
                end
                hist[i] = {hist[i][6:0], en_v[i]};

                chk(i, "busy", int'(busy_v[i]), int'(m_state[i] == 1));
                chk(i, "done", int'(done_v[i]), int'(m_state[i] == 2));
                if (done_v[i]) begin dones[i]++; done_c[i] = cyc; end

                case (m_state[i])
                    0: begin
                        exp_en[i] = 1'b0;
                        if (start_v[i]) begin
                            m_state[i] = 1;
                            m_k[i] = 0;
                            m_b[i] = 0;
                            exp_en[i] = !hold_v[i];
                            st_c[i] = cyc;
                            fen_c[i] = -1; fv_c[i] = -1; eof_c[i] = -1; done_c[i] = -1;
                            beats[i] = 0; sofs[i] = 0; eofs[i] = 0; dones[i] = 0;
                            ffn[i] = 0;
                        end
                    end
                    1: begin
                        exp_en[i] = !hold_v[i] && (m_k[i] < n);
                        if (eof_now) m_state[i] = 2;
                    end
                    default: begin
                        m_state[i] = 0;
                        exp_en[i] = 1'b0;
                    end
                endcase
            end
        end

        if (req_seq != seen_seq) begin
            seen_seq = req_seq;
            case (req_id)
                1: begin
                    chk(0, "t1_first_en_after_start", fen_c[0] - st_c[0], 1);
                    chk(0, "t1_first_valid_after_en", fv_c[0] - fen_c[0], 2);
                    chk(0, "t1_beats", beats[0], 32);
                    chk(0, "t1_sof_count", sofs[0], 1);
                    chk(0, "t1_eof_count", eofs[0], 1);
                    chk(0, "t1_eof_after_start", eof_c[0] - st_c[0], 34);
                    chk(0, "t1_done_after_eof", done_c[0] - eof_c[0], 1);
                    chk(0, "t1_done_count", dones[0], 1);
                end
                2: begin
                    chk(0, "t2_gap_5_6", bc6[0] - bc5[0], 4);
                    chk(0, "t2_gap_30_31", bc31[0] - bc30[0], 2);
                    chk(0, "t2_eof_after_start", eof_c[0] - st_c[0], 38);
                    chk(0, "t2_beats", beats[0], 32);
                    chk(0, "t2_done_count", dones[0], 1);
                end
                3: begin
                    chk(1, "t3_first_en_after_start_hold", fen_c[1] - st_c[1], 3);
                    chk(1, "t3_first_valid_after_en", fv_c[1] - fen_c[1], 4);
                    chk(1, "t3_eof_after_start", eof_c[1] - st_c[1], 38);
                    chk(1, "t3_done_after_eof", done_c[1] - eof_c[1], 1);
                    chk(1, "t3_beat7_x", b7x[1], 7);
                    chk(1, "t3_beat7_y", b7y[1], 0);
                    chk(1, "t3_beat8_x", b8x[1], 0);
                    chk(1, "t3_beat8_y", b8y[1], 1);
                    chk(1, "t3_beats", beats[1], 32);
                end
                4: begin
                    chk(0, "t4_beats", beats[0], 32);
                    chk(0, "t4_done_count", dones[0], 1);
                    chk(0, "t4_sof_count", sofs[0], 1);
                    chk(0, "t4_eof_count", eofs[0], 1);
                end
                5: begin
                    chk(0, "t5_first_en_after_start", fen_c[0] - st_c[0], 1);
                    chk(0, "t5_first_valid_after_en", fv_c[0] - fen_c[0], 2);
                    chk(0, "t5_beats", beats[0], 32);
                    chk(0, "t5_sof_count", sofs[0], 1);
                    chk(0, "t5_eof_count", eofs[0], 1);
                    chk(0, "t5_done_count", dones[0], 1);
                end
                6: begin
                    chk(2, "t6_bright_count", ffn[2], 1);
                    chk(2, "t6_bright_x", ffx[2], 3);
                    chk(2, "t6_bright_y", ffy[2], 2);
                    chk(2, "t6_beats", beats[2], 5120);
                    chk(2, "t6_eof_addr", la[2], 5119);
                    chk(2, "t6_eof_x", lx[2], 639);
                    chk(2, "t6_eof_y", ly[2], 7);
                    chk(2, "t6_eof_count", eofs[2], 1);
                    chk(2, "t6_done_after_eof", done_c[2] - eof_c[2], 1);
                end
                default: chk(0, "no_timeouts", tmo_cnt, 0);
            endcase
        end
    end

    task automatic step(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int i);
        start_v[i] = 1'b1;
        step(1);
        start_v[i] = 1'b0;
    endtask

    task automatic wait_iss(input int i, input int a, input int bound);
        int c;
        c = 0;
        while (!(en_v[i] && int'(maddr_a[i]) == a) && c < bound) begin
            step(1);
            c++;
        end
        if (!(en_v[i] && int'(maddr_a[i]) == a)) begin
            $display("FAIL timeout waiting for issue of addr %0d inst%0d", a, i);
            tmo_cnt++;
        end
    endtask

    task automatic wait_done(input int i, input int bound);
        int c;
        c = 0;
        while (!done_v[i] && c < bound) begin
            step(1);
            c++;
        end
        if (!done_v[i]) begin
            $display("FAIL timeout waiting for done inst%0d", i);
            tmo_cnt++;
        end
    endtask

    task automatic req(input int id);
        req_id = id;
        req_seq++;
        step(1);
    endtask

    initial begin
        rst_v   = '0;
        start_v = '0;
        hold_v  = '0;
        repeat (3) @(posedge clk);
        #1 rst_v = '1;
        step(2);

        // Plain scan, no stalls.
        pulse_start(0);
        wait_done(0, 200);
        step(2);
        req(1);

        // Stall 3 cycles after addr 5 issues, 1 cycle with addr 31 next.
        pulse_start(0);
        wait_iss(0, 5, 100);
        hold_v[0] = 1'b1;
        step(3);
        hold_v[0] = 1'b0;
        wait_iss(0, 30, 100);
        hold_v[0] = 1'b1;
        step(1);
        hold_v[0] = 1'b0;
        wait_done(0, 200);
        step(2);
        req(2);

        // Longer read latency, start arriving together with hold.
        start_v[1] = 1'b1;
        hold_v[1]  = 1'b1;
        step(1);
        start_v[1] = 1'b0;
        step(1);
        hold_v[1]  = 1'b0;
        wait_done(1, 200);
        step(2);
        req(3);

        // Start pulses mid-scan and in the done cycle are ignored.
        pulse_start(0);
        wait_iss(0, 10, 100);
        pulse_start(0);
        wait_done(0, 200);
        start_v[0] = 1'b1;
        step(1);
        start_v[0] = 1'b0;
        step(10);
        req(4);

        // Abort with reset during pixel 9, then a fresh scan.
        pulse_start(0);
        wait_iss(0, 9, 100);
        rst_v[0] = 1'b0;
        step(3);
        rst_v[0] = 1'b1;
        step(2);
        pulse_start(0);
        wait_done(0, 200);
        step(2);
        req(5);

        // Full-width lines, frame height shortened to bound run time.
        pulse_start(2);
        wait_done(2, 6000);
        step(2);
        req(6);

        req(7);
        step(2);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
